// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - 4-digit 7-segment scan scheduler with blanking, PWM, zero suppression, tear-free update
//
// Purpose
//   Time-multiplexes one shared segment bus across four 7-segment digits.
//   Each digit slot opens with a blanking window (everything off) so the
//   previous digit's segments cannot ghost onto the next one. The rest of
//   the slot is gated by a 16-level PWM compare for brightness. BCD words
//   arrive over a valid/ready handshake into a pending buffer and are only
//   promoted to the displayed word at a frame start, so a frame never mixes
//   two words.
//
// Ports
//   i_clk          in   1   system clock
//   i_rst          in   1   asynchronous reset, active low
//   i_bcd          in   16  four BCD nibbles, [3:0] is digit 0 (least significant)
//   i_dp           in   4   decimal point per digit, bit n belongs to digit n
//   i_bcd_valid    in   1   producer offers i_bcd/i_dp
//   o_bcd_ready    out  1   pending buffer empty; word taken on valid && ready
//   i_brightness   in   4   digit lit while pwm_cnt <= i_brightness (1/16 .. 16/16)
//   i_lz_blank     in   1   suppress leading zeros on digits 3..1
//   o_digitSelect  out  4   one-hot digit enable, polarity set by ACTIVE_LOW
//   o_LED          out  8   segments {dp,g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
//   o_frame_start  out  1   one-cycle pulse marking cycle 0 of the digit-0 slot

module seg_scan_scheduler #(
    parameter int TICK_DIV   = 5000,
    parameter int BLANK_CYC  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bcd,
    input  logic [3:0]  i_dp,
    input  logic        i_bcd_valid,
    output logic        o_bcd_ready,
    input  logic [3:0]  i_brightness,
    input  logic        i_lz_blank,
    output logic [3:0]  o_digitSelect,
    output logic [7:0]  o_LED,
    output logic        o_frame_start
);

    localparam logic [15:0] SLOT_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] BLANK_END  = 16'(BLANK_CYC);

    // Idle (inactive) levels of the pins for the chosen polarity.
    localparam logic [3:0] SEL_IDLE = ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic [7:0] LED_IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        PH_BLANK,
        PH_ON,
        PH_DIM
    } phase_t;

    // Scan counters
    logic [15:0] slot_cnt;
    logic [1:0]  digit_idx;
    logic [3:0]  pwm_cnt;

    // Word buffers
    logic [15:0] disp_bcd;
    logic [3:0]  disp_dp;
    logic [15:0] pend_bcd;
    logic [3:0]  pend_dp;
    logic        pend_full;

    // Per-cycle decode of the counters
    logic        slot_wrap;
    logic        frame_now;
    logic [3:0]  pwm_now;
    phase_t      phase;

    // Segment path
    logic [3:0]  nibble;
    logic        dp_bit;
    logic [6:0]  glyph;
    logic [3:0]  lz_mask;
    logic [7:0]  seg_hi;
    logic [3:0]  sel_hi;

    // Standard glyphs in active-high {g,f,e,d,c,b,a}; non-decimal codes show '-'.
    function automatic logic [6:0] bcd_to_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_now = (slot_cnt == 16'd0) && (digit_idx == 2'd0);

    // The PWM window restarts on the first cycle after blanking, so that
    // cycle always compares against zero regardless of the stored count.
    assign pwm_now = (slot_cnt == BLANK_END) ? 4'd0 : pwm_cnt;

    always_comb begin
        phase = PH_DIM;
        if (slot_cnt < BLANK_END) begin
            phase = PH_BLANK;
        end else if (pwm_now <= i_brightness) begin
            phase = PH_ON;
        end
    end

    // Slot, digit and PWM counters
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            slot_cnt  <= 16'd0;
            digit_idx <= 2'd0;
            pwm_cnt   <= 4'd0;
        end else begin
            if (slot_wrap) begin
                slot_cnt  <= 16'd0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                slot_cnt  <= slot_cnt + 16'd1;
            end
            pwm_cnt <= pwm_now + 4'd1;
        end
    end

    // Pending/display buffers. A full pending buffer blocks new words and is
    // promoted only on the frame-start cycle; a word accepted on that same
    // cycle lands in pending and waits for the following frame.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            disp_bcd  <= 16'd0;
            disp_dp   <= 4'd0;
            pend_bcd  <= 16'd0;
            pend_dp   <= 4'd0;
            pend_full <= 1'b0;
        end else begin
            if (frame_now && pend_full) begin
                disp_bcd  <= pend_bcd;
                disp_dp   <= pend_dp;
                pend_full <= 1'b0;
            end else if (i_bcd_valid && !pend_full) begin
                pend_bcd  <= i_bcd;
                pend_dp   <= i_dp;
                pend_full <= 1'b1;
            end
        end
    end

    assign o_bcd_ready = !pend_full;

    // Leading-zero mask: a digit is blank only if it and every more
    // significant digit is zero with no decimal point, so a lit dp anywhere
    // above keeps the zeros below it visible.
    always_comb begin
        lz_mask    = 4'b0000;
        lz_mask[3] = (disp_bcd[15:12] == 4'd0) && !disp_dp[3];
        lz_mask[2] = lz_mask[3] && (disp_bcd[11:8] == 4'd0) && !disp_dp[2];
        lz_mask[1] = lz_mask[2] && (disp_bcd[7:4] == 4'd0) && !disp_dp[1];
        if (!i_lz_blank) begin
            lz_mask = 4'b0000;
        end
    end

    always_comb begin
        nibble = 4'd0;
        dp_bit = 1'b0;
        sel_hi = 4'b0000;
        case (digit_idx)
            2'd0: begin nibble = disp_bcd[3:0];   dp_bit = disp_dp[0]; sel_hi = 4'b0001; end
            2'd1: begin nibble = disp_bcd[7:4];   dp_bit = disp_dp[1]; sel_hi = 4'b0010; end
            2'd2: begin nibble = disp_bcd[11:8];  dp_bit = disp_dp[2]; sel_hi = 4'b0100; end
            default: begin nibble = disp_bcd[15:12]; dp_bit = disp_dp[3]; sel_hi = 4'b1000; end
        endcase
    end

    always_comb begin
        glyph  = bcd_to_glyph(nibble);
        seg_hi = {dp_bit, glyph};
        if (lz_mask[digit_idx]) begin
            seg_hi = 8'h00;
        end
    end

    // Registered pin drivers: one clock behind the counters that produced them.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_digitSelect <= SEL_IDLE;
            o_LED         <= LED_IDLE;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= frame_now;
            case (phase)
                PH_ON: begin
                    o_digitSelect <= ACTIVE_LOW ? ~sel_hi : sel_hi;
                    o_LED         <= ACTIVE_LOW ? ~seg_hi : seg_hi;
                end
                default: begin
                    o_digitSelect <= SEL_IDLE;
                    o_LED         <= LED_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb/tb_seg_scan_scheduler.sv - self-checking bench for seg_scan_scheduler
module tb_seg_scan_scheduler;

    localparam int TD = 64;
    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        valid;
    logic        ready;
    logic [3:0]  bright;
    logic        lz;
    logic [3:0]  sel;
    logic [7:0]  led;
    logic        fs;

    int checks = 0;
    int failures = 0;

    seg_scan_scheduler #(.TICK_DIV(TD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_bcd         (bcd),
        .i_dp          (dp),
        .i_bcd_valid   (valid),
        .o_bcd_ready   (ready),
        .i_brightness  (bright),
        .i_lz_blank    (lz),
        .o_digitSelect (sel),
        .o_LED         (led),
        .o_frame_start (fs)
    );

    always #5 clk = ~clk;

    // Reference model: active-high glyphs {dp,g,f,e,d,c,b,a}
    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

    logic [13:0] sb [$];
    int          t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    bit          m_full;

    // Before each rising edge, predict {frame_start, ready, select, led} the
    // DUT must show just after that edge, from the elapsed cycle count.
    always @(negedge clk or negedge rst_n) begin
        int slot, idx;
        bit frame, on, blank;
        logic [3:0] nib, sel_e;
        logic [7:0] seg, led_e;
        if (!rst_n) begin
            t = 0; m_disp = 0; m_pend = 0; m_dp = 0; m_pdp = 0; m_full = 0;
            sb.delete();
        end else begin
            slot  = t % TD;
            idx   = (t / TD) % 4;
            frame = (t % (4 * TD)) == 0;
            on    = (slot >= BC) && (((slot - BC) % 16) <= int'(bright));
            nib   = 4'(m_disp >> (4 * idx));
            seg   = seg_tab[nib] | (m_dp[idx] ? 8'h80 : 8'h00);
            blank = lz && (idx != 0) && ((m_disp >> (4 * idx)) == 16'd0) && ((m_dp >> idx) == 4'd0);
            sel_e = on ? ~(4'b0001 << idx) : 4'hF;
            led_e = on ? (blank ? 8'hFF : ~seg) : 8'hFF;
            if (frame && m_full) begin
                m_disp = m_pend; m_dp = m_pdp; m_full = 0;
            end else if (valid && !m_full) begin
                m_pend = bcd; m_pdp = dp; m_full = 1;
            end
            sb.push_back({frame, !m_full, sel_e, led_e});
            t++;
        end
    end

    always @(posedge clk) begin
        logic [13:0] exp_v, got_v;
        #1;
        if (rst_n && sb.size() > 0) begin
            exp_v = sb.pop_front();
            got_v = {fs, ready, sel, led};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL scoreboard cyc=%0d got fs/rdy/sel/led=%b/%b/%h/%h want %b/%b/%h/%h",
                         t - 1, got_v[13], got_v[12], got_v[11:8], got_v[7:0],
                         exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:0]);
            end
        end
    end

    // Bench phase: inputs change at posedge+2, outputs sampled at posedge+1.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_frame_start();
        bit seen = 0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(posedge clk); #1;
            seen = (fs === 1'b1);
            #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL frame_start_timeout got=none want=pulse within 600 cycles");
        end
    endtask

    task automatic find_digit(input int k, output logic [7:0] l, output bit found);
        found = 0;
        l = 8'hxx;
        for (int n = 0; n < 400 && !found; n++) begin
            @(posedge clk); #1;
            if (sel === ~(4'b0001 << k)) begin
                found = 1;
                l = led;
            end
            #1;
        end
    endtask

    task automatic offer(input logic [15:0] b, input logic [3:0] d);
        int n = 0;
        while (ready !== 1'b1 && n < 600) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 600) begin
            failures++;
            $display("FAIL offer_timeout ready=%b want=1", ready);
        end
        bcd = b; dp = d; valid = 1'b1;
        step(1);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        step(3);
        checks += 4;
        if (sel !== 4'hF)  begin failures++; $display("FAIL reset_sel got=%h want=f", sel); end
        if (led !== 8'hFF) begin failures++; $display("FAIL reset_led got=%h want=ff", led); end
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
        if (fs !== 1'b0)   begin failures++; $display("FAIL reset_fs got=%b want=0", fs); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [7:0] l;
        bit f;
        int n;
        wait_frame_start();
        n = 0;
        f = 0;
        while (!f && n < 600) begin
            @(posedge clk); #1; f = (fs === 1'b1); #1; n++;
        end
        checks++;
        if (n !== 4 * TD) begin failures++; $display("FAIL frame_period got=%0d want=%0d", n, 4 * TD); end
        find_digit(0, l, f);
        checks++;
        if (!f || l !== 8'hC0) begin failures++; $display("FAIL idle_d0 got=%h want=c0", l); end
        find_digit(3, l, f);
        checks++;
        if (!f || l !== 8'hC0) begin failures++; $display("FAIL idle_d3_nolz got=%h want=c0", l); end
        lz = 1'b1;
        wait_frame_start();
        find_digit(3, l, f);
        checks++;
        if (!f || l !== 8'hFF) begin failures++; $display("FAIL idle_d3_lz got=%h want=ff", l); end
        lz = 1'b0;
    endtask

    task automatic test_handshake();
        logic [7:0] l;
        bit f;
        wait_frame_start();
        step(20);
        offer(16'h1234, 4'b0100);
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL hs_ready_drop got=%b want=0", ready); end
        // Held valid with different data while not ready must be ignored.
        bcd = 16'h9999; dp = 4'hF; valid = 1'b1;
        step(10);
        valid = 1'b0;
        wait_frame_start();
        find_digit(2, l, f);
        checks++;
        if (!f || l !== 8'h24) begin failures++; $display("FAIL hs_d2_dp got=%h want=24", l); end
        find_digit(3, l, f);
        checks++;
        if (!f || l !== 8'hF9) begin failures++; $display("FAIL hs_d3 got=%h want=f9", l); end
    endtask

    task automatic test_brightness();
        int cnt;
        bright = 4'd0;
        wait_frame_start();
        cnt = 0;
        for (int i = 0; i < TD - 1; i++) begin
            @(posedge clk); #1; if (sel !== 4'hF) cnt++; #1;
        end
        checks++;
        if (cnt !== 4) begin failures++; $display("FAIL bright0_on got=%0d want=4", cnt); end
        bright = 4'd15;
        wait_frame_start();
        cnt = 0;
        for (int i = 0; i < TD - 1; i++) begin
            @(posedge clk); #1; if (sel !== 4'hF) cnt++; #1;
        end
        checks++;
        if (cnt !== TD - BC) begin failures++; $display("FAIL bright15_on got=%0d want=%0d", cnt, TD - BC); end
        bright = 4'd5;
        step(300);
        bright = 4'd15;
    endtask

    task automatic test_lz_blank();
        logic [7:0] l;
        bit f;
        lz = 1'b1;
        offer(16'h0050, 4'b0000);
        wait_frame_start();
        find_digit(1, l, f);
        checks++;
        if (!f || l !== 8'h92) begin failures++; $display("FAIL lz_d1_five got=%h want=92", l); end
        find_digit(2, l, f);
        checks++;
        if (!f || l !== 8'hFF) begin failures++; $display("FAIL lz_d2_blank got=%h want=ff", l); end
        offer(16'h0000, 4'b0100);
        wait_frame_start();
        find_digit(2, l, f);
        checks++;
        if (!f || l !== 8'h40) begin failures++; $display("FAIL lz_d2_zero_dp got=%h want=40", l); end
        find_digit(3, l, f);
        checks++;
        if (!f || l !== 8'hFF) begin failures++; $display("FAIL lz_d3_blank got=%h want=ff", l); end
    endtask

    task automatic test_dash();
        logic [7:0] l;
        bit f;
        offer(16'h00AF, 4'b0000);
        wait_frame_start();
        find_digit(0, l, f);
        checks++;
        if (!f || l !== 8'hBF) begin failures++; $display("FAIL dash_d0 got=%h want=bf", l); end
        find_digit(1, l, f);
        checks++;
        if (!f || l !== 8'hBF) begin failures++; $display("FAIL dash_d1 got=%h want=bf", l); end
        lz = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] l;
        bit f;
        wait_frame_start();
        step(20);
        offer(16'h8888, 4'hF);
        step(10);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (sel !== 4'hF)   begin failures++; $display("FAIL arst_sel got=%h want=f", sel); end
        if (led !== 8'hFF)  begin failures++; $display("FAIL arst_led got=%h want=ff", led); end
        if (ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b want=1", ready); end
        if (fs !== 1'b0)    begin failures++; $display("FAIL arst_fs got=%b want=0", fs); end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        find_digit(1, l, f);
        checks++;
        if (!f || l !== 8'hC0) begin failures++; $display("FAIL arst_d1 got=%h want=c0", l); end
        wait_frame_start();
        find_digit(3, l, f);
        checks++;
        if (!f || l !== 8'hC0) begin failures++; $display("FAIL arst_lost_word got=%h want=c0", l); end
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; bcd = 16'h0; dp = 4'h0; bright = 4'd15; lz = 1'b0;
        test_reset();
        test_idle_scan();
        test_handshake();
        test_brightness();
        test_lz_blank();
        test_dash();
        test_async_reset();
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
